dataframe_merger: RTL and testbench

//  Frame-atomic N:1 AXI-Stream merger for per-channel dataframe generators.

---
 rtl/dataframe_merger_pkg.sv | 13 +
 rtl/dataframe_merger_rr_arbiter.sv | 34 +++
 rtl/dataframe_merger.sv | 147 ++++++++++++++
 tb/tb_dataframe_merger.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataframe_merger_pkg.sv
// Shared constants and FSM encoding for the frame-atomic AXI-Stream merger.
package dataframe_merger_pkg;

    localparam int RFDC_TDATA_WIDTH  = 128;
    localparam int FRAME_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dataframe_merger_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel after the last grant,
// wrapping cyclically. The parent registers the result.
module rr_arbiter
    import dataframe_merger_pkg::*;
#(
    parameter int N_CHANNEL = 4,
    parameter int IDX_W     = $clog2(N_CHANNEL)
) (
    input  logic [N_CHANNEL-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [N_CHANNEL-1:0] grant,
    output logic [IDX_W-1:0]     index,
    output logic                 any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        // Scan last+1 .. last+N so the previous winner is considered last.
        for (int i = 1; i <= N_CHANNEL; i++) begin
            cand = IDX_W'((int'(last) + i) % N_CHANNEL);
            if (!any && req[cand]) begin
                any         = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dataframe_merger.sv
// N:1 AXI-Stream merger that forwards whole TLAST-delimited frames round-robin
// and truncates frames that exceed a configurable beat limit.
module dataframe_merger
    import dataframe_merger_pkg::*;
#(
    parameter int N_CHANNEL   = 4,
    parameter int TDATA_WIDTH = RFDC_TDATA_WIDTH,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               SET_CONFIG,
    input  logic [LEN_WIDTH-1:0]               MAX_FRAME_LENGTH,
    input  logic [N_CHANNEL-1:0]               CHANNEL_MASK,
    input  logic [N_CHANNEL*TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [N_CHANNEL*TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [N_CHANNEL-1:0]               S_AXIS_TLAST,
    input  logic [N_CHANNEL-1:0]               S_AXIS_TVALID,
    output logic [N_CHANNEL-1:0]               S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]             M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0]           M_AXIS_TKEEP,
    output logic                               M_AXIS_TLAST,
    output logic                               M_AXIS_TVALID,
    input  logic                               M_AXIS_TREADY,
    output logic [$clog2(N_CHANNEL)-1:0]       GRANT_CHANNEL,
    output logic [FRAME_COUNT_WIDTH-1:0]       FRAME_COUNT,
    output logic                               DATAFRAME_MERGE_ERROR
);

    localparam int IDX_W  = $clog2(N_CHANNEL);
    localparam int KEEP_W = TDATA_WIDTH / 8;

    state_t                 state;
    logic [IDX_W-1:0]       last_ptr;
    logic [N_CHANNEL-1:0]   grant_oh;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [LEN_WIDTH-1:0]   cfg_max;
    logic [N_CHANNEL-1:0]   cfg_mask;

    logic [N_CHANNEL-1:0]   arb_grant;
    logic [IDX_W-1:0]       arb_index;
    logic                   arb_any;

    logic [TDATA_WIDTH-1:0] sel_data;
    logic [KEEP_W-1:0]      sel_keep;
    logic                   sel_last;
    logic                   sel_valid;
    logic                   out_free;
    logic                   accept;
    logic [LEN_WIDTH:0]     cnt_next;
    logic                   hit_max;

    rr_arbiter #(
        .N_CHANNEL (N_CHANNEL),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req   (S_AXIS_TVALID & cfg_mask),
        .last  (last_ptr),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    assign sel_data  = S_AXIS_TDATA[GRANT_CHANNEL*TDATA_WIDTH +: TDATA_WIDTH];
    assign sel_keep  = S_AXIS_TKEEP[GRANT_CHANNEL*KEEP_W +: KEEP_W];
    assign sel_last  = S_AXIS_TLAST[GRANT_CHANNEL];
    assign sel_valid = S_AXIS_TVALID[GRANT_CHANNEL];
    assign out_free  = ~M_AXIS_TVALID | M_AXIS_TREADY;
    assign accept    = (state == ST_XFER) && sel_valid && out_free;
    // Extra bit keeps the limit compare exact even at the top of the counter range.
    assign cnt_next  = {1'b0, beat_cnt} + 1'b1;
    assign hit_max   = (cfg_max != '0) && (cnt_next == {1'b0, cfg_max});

    always_comb begin
        S_AXIS_TREADY = '0;
        case (state)
            ST_XFER:  S_AXIS_TREADY = grant_oh & {N_CHANNEL{out_free}};
            ST_DRAIN: S_AXIS_TREADY = grant_oh;
            default:  S_AXIS_TREADY = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN || SET_CONFIG) begin
            state                 <= ST_IDLE;
            last_ptr              <= IDX_W'(N_CHANNEL - 1);
            grant_oh              <= '0;
            beat_cnt              <= '0;
            GRANT_CHANNEL         <= '0;
            M_AXIS_TDATA          <= '0;
            M_AXIS_TKEEP          <= '0;
            M_AXIS_TLAST          <= 1'b0;
            M_AXIS_TVALID         <= 1'b0;
            FRAME_COUNT           <= '0;
            DATAFRAME_MERGE_ERROR <= 1'b0;
            cfg_max               <= ARESETN ? MAX_FRAME_LENGTH : '0;
            cfg_mask              <= ARESETN ? CHANNEL_MASK : '1;
        end else begin
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TLAST  <= 1'b0;
                if (M_AXIS_TLAST)
                    FRAME_COUNT <= FRAME_COUNT + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        GRANT_CHANNEL <= arb_index;
                        grant_oh      <= arb_grant;
                        beat_cnt      <= '0;
                        state         <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept) begin
                        M_AXIS_TDATA  <= sel_data;
                        M_AXIS_TKEEP  <= sel_keep;
                        M_AXIS_TVALID <= 1'b1;
                        if (beat_cnt != '1)
                            beat_cnt <= beat_cnt + 1'b1;
                        if (sel_last) begin
                            M_AXIS_TLAST <= 1'b1;
                            last_ptr     <= GRANT_CHANNEL;
                            state        <= ST_IDLE;
                        end else if (hit_max) begin
                            M_AXIS_TLAST          <= 1'b1;
                            DATAFRAME_MERGE_ERROR <= 1'b1;
                            state                 <= ST_DRAIN;
                        end else begin
                            M_AXIS_TLAST <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Runaway tail is swallowed; the output already saw a forced TLAST.
                    if (sel_valid && sel_last) begin
                        last_ptr <= GRANT_CHANNEL;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataframe_merger.sv
// Self-checking bench for dataframe_merger: table of traffic cases plus hand-written
// truncation-continuation and mid-frame SET_CONFIG sequences, scoreboarded per beat.
module tb_dataframe_merger;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int KW = W / 8;
    localparam int LW = 16;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [N-1:0]      mask;
        logic [LW-1:0]     max_len;
        logic [N-1:0][7:0] len;
        logic [N-1:0][7:0] nfr;
        bit                rnd;
        bit                gap;
        int                exp_fc;
        bit                exp_err;
        logic [1:0]        exp_grant;
    } case_t;

    logic               ACLK = 1'b0;
    logic               ARESETN;
    logic               SET_CONFIG;
    logic [LW-1:0]      MAX_FRAME_LENGTH;
    logic [N-1:0]       CHANNEL_MASK;
    logic [N*W-1:0]     S_AXIS_TDATA;
    logic [N*KW-1:0]    S_AXIS_TKEEP;
    logic [N-1:0]       S_AXIS_TLAST;
    logic [N-1:0]       S_AXIS_TVALID;
    logic [N-1:0]       S_AXIS_TREADY;
    logic [W-1:0]       M_AXIS_TDATA;
    logic [KW-1:0]      M_AXIS_TKEEP;
    logic               M_AXIS_TLAST;
    logic               M_AXIS_TVALID;
    logic               M_AXIS_TREADY;
    logic [1:0]         GRANT_CHANNEL;
    logic [31:0]        FRAME_COUNT;
    logic               DATAFRAME_MERGE_ERROR;

    dataframe_merger #(.N_CHANNEL(N), .TDATA_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .ACLK                  (ACLK),
        .ARESETN               (ARESETN),
        .SET_CONFIG            (SET_CONFIG),
        .MAX_FRAME_LENGTH      (MAX_FRAME_LENGTH),
        .CHANNEL_MASK          (CHANNEL_MASK),
        .S_AXIS_TDATA          (S_AXIS_TDATA),
        .S_AXIS_TKEEP          (S_AXIS_TKEEP),
        .S_AXIS_TLAST          (S_AXIS_TLAST),
        .S_AXIS_TVALID         (S_AXIS_TVALID),
        .S_AXIS_TREADY         (S_AXIS_TREADY),
        .M_AXIS_TDATA          (M_AXIS_TDATA),
        .M_AXIS_TKEEP          (M_AXIS_TKEEP),
        .M_AXIS_TLAST          (M_AXIS_TLAST),
        .M_AXIS_TVALID         (M_AXIS_TVALID),
        .M_AXIS_TREADY         (M_AXIS_TREADY),
        .GRANT_CHANNEL         (GRANT_CHANNEL),
        .FRAME_COUNT           (FRAME_COUNT),
        .DATAFRAME_MERGE_ERROR (DATAFRAME_MERGE_ERROR)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t src_q [N][$];
    beat_t exp_q [$];
    int    m_fr  [N][$];
    int    fidx  [N];
    int    m_ptr;
    logic [N-1:0]  m_mask;
    logic [LW-1:0] m_max;

    bit rnd_ready = 1'b0;
    bit gap_chk   = 1'b0;
    bit after_last = 1'b0;
    int gap = 0;
    int out_beats = 0;
    logic [N-1:0] hs;
    bit stall_prev = 1'b0;
    logic [W+KW:0] held;
    beat_t e_mon;

    case_t cases [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(int c, int f, int b, int len);
        beat_t r;
        r.data = {8'(c), 8'(f), 16'(b)};
        r.keep = KW'(b * 5 + c);
        r.last = (b == len - 1);
        return r;
    endfunction

    task automatic load_frames(int c, int len, int n);
        for (int k = 0; k < n; k++) begin
            int f = fidx[c];
            fidx[c]++;
            for (int b = 0; b < len; b++) src_q[c].push_back(mk(c, f, b, len));
            m_fr[c].push_back((f << 16) | len);
        end
    endtask

    // Expected output order: whole frames round-robin, truncated at the beat limit.
    task automatic model_run();
        bit found;
        int c, fr, f, len;
        beat_t bt;
        forever begin
            found = 1'b0;
            c = 0;
            for (int i = 1; i <= N; i++) begin
                int cc = (m_ptr + i) % N;
                if (!found && m_mask[cc] && m_fr[cc].size() != 0) begin
                    found = 1'b1;
                    c = cc;
                end
            end
            if (!found) break;
            fr  = m_fr[c].pop_front();
            f   = fr >> 16;
            len = fr & 16'hFFFF;
            for (int b = 0; b < len; b++) begin
                bt = mk(c, f, b, len);
                if (!bt.last && m_max != 0 && b + 1 == int'(m_max)) begin
                    bt.last = 1'b1;
                    exp_q.push_back(bt);
                    break;
                end
                exp_q.push_back(bt);
            end
            m_ptr = c;
        end
    endtask

    task automatic apply_config(input logic [N-1:0] mask, input logic [LW-1:0] maxl);
        @(posedge ACLK); #2;
        SET_CONFIG = 1'b1; CHANNEL_MASK = mask; MAX_FRAME_LENGTH = maxl;
        @(posedge ACLK); #2;
        SET_CONFIG = 1'b0;
        m_mask = mask; m_max = maxl; m_ptr = N - 1;
    endtask

    task automatic flush_now();
        for (int c = 0; c < N; c++) begin
            src_q[c].delete();
            m_fr[c].delete();
        end
        exp_q.delete();
        S_AXIS_TVALID = '0;
    endtask

    task automatic flush();
        @(negedge ACLK); #1;
        flush_now();
    endtask

    function automatic bit src_idle();
        for (int c = 0; c < N; c++)
            if (m_mask[c] && src_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge ACLK);
            if (exp_q.size() == 0 && src_idle()) begin
                done = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge ACLK);
        check("traffic_done", 64'(done), 64'd1);
    endtask

    // Source side: handshake seen at negedge is retired after the next edge.
    initial begin
        forever begin
            @(negedge ACLK);
            hs = S_AXIS_TVALID & S_AXIS_TREADY;
            @(posedge ACLK); #1;
            for (int c = 0; c < N; c++) begin
                if (hs[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
                if (src_q[c].size() != 0) begin
                    S_AXIS_TVALID[c]          = 1'b1;
                    S_AXIS_TDATA[c*W +: W]    = src_q[c][0].data;
                    S_AXIS_TKEEP[c*KW +: KW]  = src_q[c][0].keep;
                    S_AXIS_TLAST[c]           = src_q[c][0].last;
                end else begin
                    S_AXIS_TVALID[c] = 1'b0;
                end
            end
            M_AXIS_TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Sink side: scoreboard compare, stall stability and inter-frame bubble.
    initial begin
        forever begin
            @(negedge ACLK);
            if (stall_prev)
                check("stall_hold", 64'({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}),
                      64'({1'b1, held}));
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                out_beats++;
                if (gap_chk && after_last) check("bubble", 64'(gap), 64'd1);
                after_last = M_AXIS_TLAST;
                gap = 0;
                check("exp_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    check("beat", 64'({M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}),
                          64'({e_mon.last, e_mon.keep, e_mon.data}));
                end
            end else if (after_last && !M_AXIS_TVALID) begin
                gap++;
            end
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            held = {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA};
        end
    end

    initial begin
        //            mask   max     len ch3..ch0                     nfr ch3..ch0                    rnd gap fc err grant
        cases[0] = '{4'hF, 16'd0, {8'd0, 8'd0, 8'd0, 8'd4},  {8'd0,  8'd0,  8'd0,  8'd1},  1'b0, 1'b0, 1,  1'b0, 2'd0};
        cases[1] = '{4'hF, 16'd0, {8'd3, 8'd3, 8'd3, 8'd3},  {8'd1,  8'd1,  8'd1,  8'd2},  1'b0, 1'b1, 5,  1'b0, 2'd0};
        cases[2] = '{4'hF, 16'd8, {8'd0, 8'd20, 8'd0, 8'd0}, {8'd0,  8'd1,  8'd0,  8'd0},  1'b0, 1'b0, 1,  1'b1, 2'd2};
        cases[3] = '{4'hF, 16'd0, {8'd7, 8'd1, 8'd3, 8'd5},  {8'd16, 8'd16, 8'd16, 8'd16}, 1'b1, 1'b0, 64, 1'b0, 2'd3};
        cases[4] = '{4'h5, 16'd0, {8'd2, 8'd2, 8'd2, 8'd2},  {8'd3,  8'd3,  8'd3,  8'd3},  1'b0, 1'b0, 6,  1'b0, 2'd2};
        cases[5] = '{4'hF, 16'd1, {8'd0, 8'd0, 8'd0, 8'd3},  {8'd0,  8'd0,  8'd0,  8'd2},  1'b0, 1'b0, 2,  1'b1, 2'd0};
        cases[6] = '{4'hF, 16'd4, {8'd0, 8'd0, 8'd4, 8'd0},  {8'd0,  8'd0,  8'd2,  8'd0},  1'b0, 1'b0, 2,  1'b0, 2'd1};
        cases[7] = '{4'hF, 16'd0, {8'd1, 8'd0, 8'd0, 8'd0},  {8'd3,  8'd0,  8'd0,  8'd0},  1'b1, 1'b0, 3,  1'b0, 2'd3};

        for (int c = 0; c < N; c++) fidx[c] = 0;
        m_mask = '1; m_max = '0; m_ptr = N - 1;
        ARESETN = 1'b0; SET_CONFIG = 1'b0; MAX_FRAME_LENGTH = '0; CHANNEL_MASK = '0;
        S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0; S_AXIS_TLAST = '0; S_AXIS_TVALID = '0;
        M_AXIS_TREADY = 1'b0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_m_valid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_m_last",  64'(M_AXIS_TLAST), 64'd0);
        check("rst_m_data",  64'({M_AXIS_TKEEP, M_AXIS_TDATA}), 64'd0);
        check("rst_s_ready", 64'(S_AXIS_TREADY), 64'd0);
        check("rst_fc",      64'(FRAME_COUNT), 64'd0);
        check("rst_err",     64'(DATAFRAME_MERGE_ERROR), 64'd0);
        check("rst_grant",   64'(GRANT_CHANNEL), 64'd0);
        @(posedge ACLK); #2;
        ARESETN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rnd_ready = cases[i].rnd;
            apply_config(cases[i].mask, cases[i].max_len);
            @(negedge ACLK); #1;
            after_last = 1'b0; gap_chk = cases[i].gap; out_beats = 0;
            for (int c = 0; c < N; c++) load_frames(c, int'(cases[i].len[c]), int'(cases[i].nfr[c]));
            model_run();
            wait_done(5000);
            check("frame_count", 64'(FRAME_COUNT), 64'(cases[i].exp_fc));
            check("merge_error", 64'(DATAFRAME_MERGE_ERROR), 64'(cases[i].exp_err));
            check("grant_channel", 64'(GRANT_CHANNEL), 64'(cases[i].exp_grant));
            if (cases[i].mask == 4'h5)
                check("masked_untouched", 64'(src_q[1].size() + src_q[3].size()), 64'd12);
            if (i == 2) begin
                // After truncation the next ch2 frame must pass intact; error stays set.
                @(negedge ACLK); #1;
                load_frames(2, 5, 1);
                model_run();
                wait_done(2000);
                check("post_trunc_fc", 64'(FRAME_COUNT), 64'd2);
                check("err_sticky", 64'(DATAFRAME_MERGE_ERROR), 64'd1);
                check("post_trunc_grant", 64'(GRANT_CHANNEL), 64'd2);
            end
            gap_chk = 1'b0;
            flush();
        end

        // SET_CONFIG mid-frame: ch0 truncated first (err, count 1), then ch1 cut at beat ~3.
        begin
            bit hit = 1'b0;
            rnd_ready = 1'b0;
            apply_config(4'hF, 16'd12);
            @(negedge ACLK); #1;
            out_beats = 0;
            load_frames(0, 14, 1);
            load_frames(1, 10, 1);
            model_run();
            for (int k = 0; k < 2000; k++) begin
                @(negedge ACLK);
                if (out_beats >= 15) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("midframe_reached", 64'(hit), 64'd1);
            check("pre_cfg_fc", 64'(FRAME_COUNT), 64'd1);
            check("pre_cfg_err", 64'(DATAFRAME_MERGE_ERROR), 64'd1);
            check("pre_cfg_grant", 64'(GRANT_CHANNEL), 64'd1);
            @(posedge ACLK); #2;
            SET_CONFIG = 1'b1; CHANNEL_MASK = 4'b0010; MAX_FRAME_LENGTH = 16'd1;
            @(posedge ACLK); #2;
            SET_CONFIG = 1'b0;
            @(negedge ACLK);
            check("cfg_m_valid", 64'({M_AXIS_TVALID, M_AXIS_TLAST}), 64'd0);
            check("cfg_m_data",  64'({M_AXIS_TKEEP, M_AXIS_TDATA}), 64'd0);
            check("cfg_fc",      64'(FRAME_COUNT), 64'd0);
            check("cfg_err",     64'(DATAFRAME_MERGE_ERROR), 64'd0);
            check("cfg_grant",   64'(GRANT_CHANNEL), 64'd0);
            check("cfg_s_ready", 64'(S_AXIS_TREADY), 64'd0);
            #1;
            flush_now();
            m_mask = 4'b0010; m_max = 16'd1; m_ptr = N - 1;
            @(negedge ACLK); #1;
            load_frames(1, 2, 2);
            load_frames(0, 3, 1);
            model_run();
            wait_done(2000);
            check("newcfg_fc", 64'(FRAME_COUNT), 64'd2);
            check("newcfg_err", 64'(DATAFRAME_MERGE_ERROR), 64'd1);
            check("newcfg_grant", 64'(GRANT_CHANNEL), 64'd1);
            check("newcfg_mask", 64'(src_q[0].size()), 64'd3);
            flush();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
